// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and iteration count.
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation.
// y = en ? -a : a, wrapping mod 2^W.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    // pass through or negate
    always_comb begin
        y = en ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO.
// Magnitudes iterate; signs are fixed up in a single FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               is_mul_q, is_mul_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               op_signed;
    logic               op_mul;
    logic               op_div;
    logic               rt_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_step, div_step;

    assign accept    = start & ~busy_q;
    assign op_signed = (op == OP_MULT) | (op == OP_DIV);
    assign op_mul    = (op == OP_MULT) | (op == OP_MULTU);
    assign op_div    = (op == OP_DIV) | (op == OP_DIVU);
    assign rt_zero   = (rt_data == '0);

    mdu_negate #(.W(WIDTH)) u_abs_a (
        .en (op_signed & rs_data[WIDTH-1]),
        .a  (rs_data),
        .y  (abs_a)
    );

    mdu_negate #(.W(WIDTH)) u_abs_b (
        .en (op_signed & rt_data[WIDTH-1]),
        .a  (rt_data),
        .y  (abs_b)
    );

    mdu_negate #(.W(2*WIDTH)) u_prod (
        .en (sa_q ^ sb_q),
        .a  (acc_q),
        .y  (prod_fix)
    );

    mdu_negate #(.W(WIDTH)) u_quo (
        .en (sa_q ^ sb_q),
        .a  (acc_q[WIDTH-1:0]),
        .y  (quo_fix)
    );

    mdu_negate #(.W(WIDTH)) u_rem (
        .en (sa_q),
        .a  (acc_q[2*WIDTH-1:WIDTH]),
        .y  (rem_fix)
    );

    // one iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, m_q};
        if (!diff[WIDTH]) begin
            div_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // next-state logic: issue, iterate, sign-fix and commit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        acc_d    = acc_q;
        is_mul_d = is_mul_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && (op_mul || op_div)) begin
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    is_mul_d = op_mul;
                    sa_d     = op_signed & rs_data[WIDTH-1];
                    sb_d     = op_signed & rt_data[WIDTH-1];
                    dbz_d    = op_div & rt_zero;
                    if (op_mul) begin
                        m_d     = abs_a;
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        state_d = S_RUN;
                    end else if (rt_zero) begin
                        // divide by zero keeps raw rs for HI
                        m_d     = rs_data;
                        state_d = S_FIX;
                    end else begin
                        m_d     = abs_b;
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        state_d = S_RUN;
                    end
                end else if (accept && op == OP_MTHI) begin
                    hi_d = rs_data;
                end else if (accept && op == OP_MTLO) begin
                    lo_d = rs_data;
                end
            end
            S_RUN: begin
                acc_d = is_mul_q ? mul_step : div_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dbz_q) begin
                    hi_d = m_q;
                    lo_d = '1;
                end else if (is_mul_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            is_mul_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            is_mul_q <= is_mul_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit.
// Expected values are hand-computed constants.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // issue one op and wait (bounded) for done; caller sits #1 after an edge
    task automatic run_op(input  logic [2:0]  o,
                          input  logic [31:0] a,
                          input  logic [31:0] b,
                          output int          cyc,
                          output int          bcyc);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        bcyc  = 0;
        while (!done && cyc < 100) begin
            if (busy) bcyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int cyc, bcyc;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 3'd7;
        rs_data  = '0;
        rt_data  = '0;
        step();
        step();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_flags", {busy, done, div_by_zero}, 3'b000);
        rst = 1'b1;
        step();

        // 1: MULTU max * max, latency and busy width
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc);
        check("multu_lat", cyc, 33);
        check("multu_busy", bcyc, 33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        step();
        check("done_pulse", done, 1'b0);

        // 2: MULT -3*5, then DIVU 32/12 back-to-back with done
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, cyc, bcyc);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        run_op(3'd3, 32'd32, 32'd12, cyc, bcyc);
        check("divu_lat", cyc, 33);
        check("divu_lo", lo, 32'd2);
        check("divu_hi", hi, 32'd8);

        // 3: signed divides incl. overflow corner
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc, bcyc);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 32'h0);

        // 4: divide by zero, then MULTU clears the flag
        run_op(3'd3, 32'd5, 32'd0, cyc, bcyc);
        check("dbz_lat", cyc, 1);
        check("dbz_flag", div_by_zero, 1'b1);
        check("dbz_hi", hi, 32'd5);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        start   = 1'b1;
        op      = 3'd1;
        rs_data = 32'd3;
        rt_data = 32'd4;
        step();
        start = 1'b0;
        check("dbz_clr", div_by_zero, 1'b0);
        check("dbz_busy", busy, 1'b1);
        cyc = 0;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
        check("multu_small_lo", lo, 32'd12);

        // MTHI sets hi in one edge, no done
        start   = 1'b1;
        op      = 3'd4;
        rs_data = 32'h55AA;
        step();
        start = 1'b0;
        check("mthi_hi", hi, 32'h55AA);
        check("mthi_flags", {busy, done}, 2'b00);

        // 5: starts while busy are dropped
        start   = 1'b1;
        op      = 3'd0;
        rs_data = 32'd7;
        rt_data = 32'hFFFF_FFFE;
        step();
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 100) begin
            step();
            cyc++;
            if (cyc == 4) begin
                start   = 1'b1;
                op      = 3'd4;
                rs_data = 32'h1234;
            end else if (cyc == 9) begin
                start   = 1'b1;
                op      = 3'd3;
                rs_data = 32'd100;
                rt_data = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (cyc == 20) check("run_hi_stable", hi, 32'h55AA);
        end
        start = 1'b0;
        check("busy_drop_lat", cyc, 33);
        check("busy_drop_hi", hi, 32'hFFFF_FFFF);
        check("busy_drop_lo", lo, 32'hFFFF_FFF2);
        step();
        check("busy_drop_idle", busy, 1'b0);

        // 6: reset mid-run, then MTLO
        start   = 1'b1;
        op      = 3'd1;
        rs_data = 32'd9;
        rt_data = 32'd9;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b0;
        step();
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_flags", {busy, done}, 2'b00);
        rst = 1'b1;
        step();
        start   = 1'b1;
        op      = 3'd5;
        rs_data = 32'hABCD;
        step();
        start = 1'b0;
        check("mtlo_lo", lo, 32'hABCD);
        check("mtlo_done", {busy, done}, 2'b00);
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) check("spurious_done", done, 1'b0);
        end
        check("mtlo_keep", lo, 32'hABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
